// File: rtl/packet_serializer_pkg.sv
// Shared definitions for the packet serializer slice.
// Holds the packet geometry, the header field positions, the FSM state type
// and helpers that pull strobe/data word i out of a packed packet.
// Packet layout, LSB first: header, MAX_BEATS strobes, MAX_BEATS data words.
package serializer_pkg;

  localparam int HEADER_SIZE = 102;
  localparam int MAX_BEATS   = 4;
  localparam int STRB_SIZE   = 16;
  localparam int BEAT_SIZE   = 128;
  localparam int DATA_SIZE   = HEADER_SIZE + MAX_BEATS * (STRB_SIZE + BEAT_SIZE);
  localparam int WRITE_BIT   = 0;
  localparam int LEN_LSB     = 1;
  localparam int LEN_WIDTH   = $clog2(MAX_BEATS);
  localparam int COUNT_SIZE  = 32;

  // Strobes sit directly above the header, data words above all strobes.
  localparam int STRB_BASE = HEADER_SIZE;
  localparam int DATA_BASE = HEADER_SIZE + MAX_BEATS * STRB_SIZE;

  typedef logic [DATA_SIZE-1:0] packet_t;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    DATA
  } state_t;

  function automatic logic [STRB_SIZE-1:0] packet_strb(input packet_t pkt,
                                                       input logic [LEN_WIDTH-1:0] idx);
    return pkt[STRB_BASE + int'(idx) * STRB_SIZE +: STRB_SIZE];
  endfunction

  function automatic logic [BEAT_SIZE-1:0] packet_beat(input packet_t pkt,
                                                       input logic [LEN_WIDTH-1:0] idx);
    return pkt[DATA_BASE + int'(idx) * BEAT_SIZE +: BEAT_SIZE];
  endfunction

endpackage

// File: rtl/packet_serializer_if.sv
// Bundle of the serializer's handshake channels.
// Upstream: queues_to_serializer_valid/packet in, serializer_to_scheduler_ready out.
// Downstream: header channel (valid/ready/header) and beat channel
// (valid/ready/data/strb/last).
// master: the serializer itself; slave: the queue/scheduler and AXI adapter side.
interface packet_serializer_if;
  import serializer_pkg::*;

  logic                   queues_to_serializer_valid;
  packet_t                queues_to_serializer_packet;
  logic                   serializer_to_scheduler_ready;
  logic                   header_valid;
  logic                   header_ready;
  logic [HEADER_SIZE-1:0] header;
  logic                   beat_valid;
  logic                   beat_ready;
  logic [BEAT_SIZE-1:0]   beat_data;
  logic [STRB_SIZE-1:0]   beat_strb;
  logic                   beat_last;

  modport master (
    input  queues_to_serializer_valid, queues_to_serializer_packet,
           header_ready, beat_ready,
    output serializer_to_scheduler_ready, header_valid, header,
           beat_valid, beat_data, beat_strb, beat_last
  );

  modport slave (
    output queues_to_serializer_valid, queues_to_serializer_packet,
           header_ready, beat_ready,
    input  serializer_to_scheduler_ready, header_valid, header,
           beat_valid, beat_data, beat_strb, beat_last
  );

endinterface

// File: rtl/packet_serializer_beat_selector.sv
// Combinational beat mux for the serializer.
// Ports: packet (registered packet), index (current beat number),
//        beat_data / beat_strb (selected data word and strobes).
// The index is LEN_WIDTH bits wide, so it can only address real beats.
module beat_selector
  import serializer_pkg::*;
(
  input  packet_t                packet,
  input  logic [LEN_WIDTH-1:0]   index,
  output logic [BEAT_SIZE-1:0]   beat_data,
  output logic [STRB_SIZE-1:0]   beat_strb
);

  // Pick strobe and data word for the current beat out of the held packet.
  always_comb begin
    beat_data = packet_beat(packet, index);
    beat_strb = packet_strb(packet, index);
  end

endmodule

// File: rtl/packet_serializer.sv
// Packet serializer: accepts one packed packet and replays it as a header
// transfer followed by 1..MAX_BEATS data beats (write packets only).
// Ports: clock, reset (async, active low), bus (handshake channels, master
//        side), busy (a packet is in flight), packets_sent (completed packets,
//        wrapping counter).
module packet_serializer
  import serializer_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  packet_serializer_if.master   bus,
  output logic                  busy,
  output logic [COUNT_SIZE-1:0] packets_sent
);

  state_t               state;
  packet_t              packet_reg;
  logic [LEN_WIDTH-1:0] beat_index;
  logic [LEN_WIDTH-1:0] last_index;
  logic                 ready_reg;
  logic                 header_valid_reg;
  logic                 beat_valid_reg;
  logic                 beat_last;

  // The header length field holds beats-1, i.e. the index of the final beat.
  assign last_index = packet_reg[LEN_LSB +: LEN_WIDTH];
  assign beat_last  = (beat_index == last_index);

  assign bus.serializer_to_scheduler_ready = ready_reg;
  assign bus.header_valid                  = header_valid_reg;
  assign bus.header                        = packet_reg[HEADER_SIZE-1:0];
  assign bus.beat_valid                    = beat_valid_reg;
  assign bus.beat_last                     = beat_last;

  beat_selector u_beat_selector (
    .packet    (packet_reg),
    .index     (beat_index),
    .beat_data (bus.beat_data),
    .beat_strb (bus.beat_strb)
  );

  // Main FSM. Valids, ready and busy are registered alongside the state so they
  // never depend combinationally on the input handshake. ready stays low while
  // reset is held and comes up on the first clock after release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      packet_reg       <= '0;
      beat_index       <= '0;
      packets_sent     <= '0;
      ready_reg        <= 1'b0;
      header_valid_reg <= 1'b0;
      beat_valid_reg   <= 1'b0;
      busy             <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ready_reg && bus.queues_to_serializer_valid) begin
            packet_reg       <= bus.queues_to_serializer_packet;
            beat_index       <= '0;
            state            <= HEADER;
            ready_reg        <= 1'b0;
            header_valid_reg <= 1'b1;
            busy             <= 1'b1;
          end else begin
            ready_reg <= 1'b1;
          end
        end
        HEADER: begin
          if (bus.header_ready) begin
            header_valid_reg <= 1'b0;
            if (packet_reg[WRITE_BIT]) begin
              state          <= DATA;
              beat_valid_reg <= 1'b1;
            end else begin
              state        <= IDLE;
              ready_reg    <= 1'b1;
              busy         <= 1'b0;
              packets_sent <= packets_sent + 1'b1;
            end
          end
        end
        DATA: begin
          if (bus.beat_ready) begin
            if (beat_last) begin
              state          <= IDLE;
              beat_valid_reg <= 1'b0;
              ready_reg      <= 1'b1;
              busy           <= 1'b0;
              packets_sent   <= packets_sent + 1'b1;
            end else begin
              beat_index <= beat_index + 1'b1;
            end
          end
        end
        default: begin
          state            <= IDLE;
          ready_reg        <= 1'b0;
          header_valid_reg <= 1'b0;
          beat_valid_reg   <= 1'b0;
          busy             <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/packet_serializer.md
Name: packet_serializer

Overview:
- Sits downstream of the queueing domain and scheduler. It is the consumer end of the queues-to-serializer decoupled interface.
- Accepts one scheduled packet, registers it, and unpacks it into one header transfer followed by 0..MAX_BEATS data beats, each on its own valid/ready channel. The downstream AXI master-side adapter consumes these channels.
- It is the inverse of the packetizers, which pack header, strobes and data into one packet.

Parameters:
- HEADER_SIZE, 102, header field width.
- MAX_BEATS, 4, max data beats per packet.
- STRB_SIZE, 16, strobe bits per beat.
- BEAT_SIZE, 128, data bits per beat.
- DATA_SIZE, HEADER_SIZE+MAX_BEATS*(STRB_SIZE+BEAT_SIZE), packet width.
- WRITE_BIT, 0, header bit index: 1 = write packet (carries beats), 0 = read (header only).
- LEN_LSB, 1, LSB of the header field holding beats-1 ($clog2(MAX_BEATS) bits).
- COUNT_SIZE, 32, width of the packets-sent counter.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- queues_to_serializer_valid  in  1  packet available from the selected queue.
- queues_to_serializer_packet  in  DATA_SIZE  packet.
- serializer_to_scheduler_ready  out  1  serializer can accept a packet.
- header_valid  out  1  header transfer valid.
- header_ready  in  1  downstream accepts header.
- header  out  HEADER_SIZE  registered header.
- beat_valid  out  1  data beat valid.
- beat_ready  in  1  downstream accepts beat.
- beat_data  out  BEAT_SIZE  current beat data.
- beat_strb  out  STRB_SIZE  current beat byte strobes.
- beat_last  out  1  current beat is final beat of the packet.
- busy  out  1  state != IDLE.
- packets_sent  out  COUNT_SIZE  completed packets, wraps modulo 2^COUNT_SIZE.

Behaviour:
- Packet layout, LSB first: header[HEADER_SIZE-1:0], then MAX_BEATS strobes (beat 0 lowest), then MAX_BEATS data words (beat 0 lowest).
- Reset (reset==0, async): state=IDLE, beat index=0, packet register=0, packets_sent=0. All valids=0, busy=0, serializer_to_scheduler_ready=0 while reset is asserted.
- serializer_to_scheduler_ready = (state==IDLE), registered-state driven, never combinationally dependent on queues_to_serializer_valid.
- IDLE: on valid && ready, capture the packet into a register, clear the beat index, go to HEADER next cycle.
- HEADER: header_valid=1, header from the register, held stable until the handshake.
  - On header_ready with WRITE_BIT=1, go to DATA.
  - On header_ready with WRITE_BIT=0, go to IDLE and increment packets_sent.
- DATA: beat_valid=1.
  - beat_data and beat_strb are selected from the register by beat index.
  - beat_last = (index == header length field).
  - Payload is held stable while beat_ready=0.
  - On handshake with beat_last=0: index+1.
  - On handshake with beat_last=1: go to IDLE and increment packets_sent.
- Beat count = length field + 1, range 1..MAX_BEATS. Beats beyond the count are never emitted.
- Latency: acceptance at cycle t gives header_valid at t+1. The first beat comes the cycle after the header handshake.
- Minimum period per packet:
  - write: N+2 cycles (accept, header, N beats);
  - read: 2 cycles.
- header_valid and beat_valid are never high together. Neither drops without its handshake.
- Simultaneous events:
  - Input valid is ignored outside IDLE; the input packet may change without effect.
  - ready/valid arriving on the same cycle the state leaves is consumed exactly once.
- Reset mid-operation aborts the packet:
  - no further header or beats are emitted;
  - packets_sent is cleared;
  - the upstream queue has already popped the packet, and the loss is accepted.
- Outputs are X-free after reset: beat mux index is in range 0..MAX_BEATS-1.

Decomposition:
- Shared package serializer_pkg: typedef state_t {IDLE, HEADER, DATA}; constants for WRITE_BIT, LEN_LSB, LEN_WIDTH=$clog2(MAX_BEATS); helper functions extracting strobe and beat i from a packet vector.
- One sub-module: beat_selector, combinational mux from the registered packet and index to {beat_data, beat_strb}. The FSM, counters and register stay in packet_serializer.

Test Plan:
- Reset then idle: reset low 3 cycles, release → ready=1, header_valid=0, beat_valid=0, packets_sent=0.
- Read packet: header with WRITE_BIT=0, header_ready=1 → header_valid exactly 1 cycle at t+1, no beats, ready back at t+2, packets_sent=1.
- Write, 4 beats (len=3), data words 0xA0..0xA3, strobes 0xFFFF, all readies high → beats A0,A1,A2,A3 on consecutive cycles, beat_last only on A3, next ready at t+6.
- Backpressure: write len=1, header_ready low 5 cycles, then beat_ready toggled 1/0 → header and beat 0 held stable while stalled, exactly 2 beats, no duplicates.
- Input ignored while busy: change packet and hold valid high during DATA → emitted beats match the captured packet; second packet accepted only after return to IDLE.
- Reset mid-burst: assert reset after beat 1 of 4 → beat_valid=0 immediately (async), packets_sent=0, state IDLE after release, next packet serialized correctly.
